// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding and default word widths,
// used by the slave, the memory stage and the top wrapper.
package spi_pkg;

  localparam int DIN_WIDTH_DEF  = 10;
  localparam int DOUT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises a DIN_WIDTH command word from MOSI (rx_valid one cycle
// after the last bit) and serialises a DOUT_WIDTH read word onto MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
  parameter int DOUT_WIDTH = DOUT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DIN_WIDTH-1:0]  rx_data,
  output logic                  rx_valid,
  input  logic [DOUT_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int CW  = $clog2(DIN_WIDTH);
  localparam int TCW = $clog2(DOUT_WIDTH);
  localparam logic [CW-1:0]  BIT_LAST = CW'(DIN_WIDTH - 2);
  localparam logic [CW-1:0]  BIT_DONE = CW'(DIN_WIDTH - 1);
  localparam logic [TCW-1:0] TX_LAST  = TCW'(DOUT_WIDTH - 1);

  spi_state_e state_q, state_d;

  logic [CW-1:0]         bit_cnt;
  logic [DIN_WIDTH-2:0]  shreg;
  logic                  addr_rcvd;
  logic [DOUT_WIDTH-2:0] tx_sh;
  logic [TCW-1:0]        tx_cnt;
  logic                  tx_active;
  logic                  tx_done;
  logic                  miso_q;

  logic abort;
  logic sample;
  logic last_bit;
  logic tx_accept;

  always_comb begin
    state_d   = state_q;
    abort     = 1'b0;
    sample    = 1'b0;
    last_bit  = 1'b0;
    tx_accept = 1'b0;

    if (state_q != IDLE && SS_n) begin
      abort   = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!SS_n) state_d = CHK_CMD;
        CHK_CMD: state_d = !MOSI ? WRITE : (addr_rcvd ? READ_DATA : READ_ADD);
        default: ;
      endcase
    end

    // Payload bits are taken only until the word is complete; afterwards the
    // state is held and MOSI is ignored until the master releases SS_n.
    if (!abort && (state_q == WRITE || state_q == READ_ADD || state_q == READ_DATA)
        && bit_cnt != BIT_DONE) begin
      sample   = 1'b1;
      last_bit = (bit_cnt == BIT_LAST);
    end

    tx_accept = !abort && state_q == READ_DATA && bit_cnt == BIT_DONE
                && !tx_active && !tx_done && tx_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      addr_rcvd <= 1'b0;
      tx_sh     <= '0;
      tx_cnt    <= '0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_valid <= 1'b0;

      if (abort) begin
        bit_cnt   <= '0;
        shreg     <= '0;
        tx_sh     <= '0;
        tx_cnt    <= '0;
        tx_active <= 1'b0;
        tx_done   <= 1'b0;
        miso_q    <= 1'b0;
      end else begin
        if (state_q == CHK_CMD) begin
          shreg <= {shreg[DIN_WIDTH-3:0], MOSI};
        end

        if (sample) begin
          shreg   <= {shreg[DIN_WIDTH-3:0], MOSI};
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            rx_data  <= {shreg, MOSI};
            rx_valid <= 1'b1;
            if (state_q == READ_ADD)  addr_rcvd <= 1'b1;
            if (state_q == READ_DATA) addr_rcvd <= 1'b0;
          end
        end

        // MISO is registered: the MSB appears in the cycle after tx_valid is taken.
        if (tx_accept) begin
          miso_q    <= tx_data[DOUT_WIDTH-1];
          tx_sh     <= tx_data[DOUT_WIDTH-2:0];
          tx_cnt    <= TX_LAST;
          tx_active <= 1'b1;
        end else if (tx_active) begin
          if (tx_cnt != '0) begin
            miso_q <= tx_sh[DOUT_WIDTH-2];
            tx_sh  <= {tx_sh[DOUT_WIDTH-3:0], 1'b0};
            tx_cnt <= tx_cnt - 1'b1;
          end else begin
            miso_q    <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
          end
        end
      end
    end
  end

  assign MISO = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write/read frames, abort, reset during shift-out
// and stray tx_valid, with hand-computed expected words and MISO bit streams.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int vec_cnt;
  int err_cnt;
  int rv_cnt;
  int miso_hi_cnt;

  spi_slave #(.DIN_WIDTH(10), .DOUT_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rv_cnt = rv_cnt + 1;
    if (MISO)     miso_hi_cnt = miso_hi_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one full frame; returns #1 after the edge that samples bit 0.
  task automatic frame(input logic [9:0] w);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk); MOSI = w[i];
    end
    chk("rx_valid_early", {31'b0, rx_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rx_valid", {31'b0, rx_valid}, 32'd1);
    chk("rx_data", {22'b0, rx_data}, {22'b0, w});
  endtask

  task automatic end_frame();
    @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
    @(posedge clk); #1;
    chk("state_idle_after_frame", 32'(dut.state_q), 32'(IDLE));
  endtask

  initial begin
    int rv0;
    int mh0;
    logic [7:0] rd;
    vec_cnt = 0; err_cnt = 0; rv_cnt = 0; miso_hi_cnt = 0;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_miso", {31'b0, MISO}, 32'd0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_rx_data", {22'b0, rx_data}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_addr_rcvd", {31'b0, dut.addr_rcvd}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Write address, then idle bits with SS_n still low must not re-sample
    rv0 = rv_cnt;
    frame(10'h005);
    chk("wa_addr_rcvd", {31'b0, dut.addr_rcvd}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); MOSI = 1'b1;
    end
    #1;
    chk("wa_rx_valid_count", 32'(rv_cnt - rv0), 32'd1);
    chk("wa_rx_data_held", {22'b0, rx_data}, 32'h005);
    end_frame();

    // Write data
    rv0 = rv_cnt;
    frame(10'h1AA);
    @(posedge clk); #1;
    chk("wd_rx_valid_one_cycle", {31'b0, rx_valid}, 32'd0);
    end_frame();
    chk("wd_rx_valid_count", 32'(rv_cnt - rv0), 32'd1);

    // Read address then read data with MISO shift-out and a second tx_valid mid-shift
    frame(10'h205);
    chk("ra_addr_rcvd_set", {31'b0, dut.addr_rcvd}, 32'd1);
    end_frame();
    frame(10'h3C3);
    chk("rd_addr_rcvd_clr", {31'b0, dut.addr_rcvd}, 32'd0);
    @(posedge clk); #1;
    chk("rd_miso_wait", {31'b0, MISO}, 32'd0);
    tx_valid = 1'b1; tx_data = 8'hAA;
    rd = 8'hAA;
    for (int k = 7; k >= 0; k--) begin
      @(posedge clk); #1;
      chk($sformatf("rd_miso_bit%0d", k), {31'b0, MISO}, {31'b0, rd[k]});
      tx_valid = (k == 4);
      tx_data  = (k == 4) ? 8'h55 : 8'h00;
    end
    @(posedge clk); #1;
    chk("rd_miso_after", {31'b0, MISO}, 32'd0);
    mh0 = miso_hi_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rd_miso_quiet", 32'(miso_hi_cnt - mh0), 32'd0);
    end_frame();

    // Abort after 5 bits, then a clean frame
    rv0 = rv_cnt;
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); MOSI = (i % 2 == 0);
    end
    @(negedge clk); SS_n = 1'b1;
    @(posedge clk); #1;
    chk("ab_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1;
    chk("ab_no_rx_valid", 32'(rv_cnt - rv0), 32'd0);
    frame(10'h0B4);
    end_frame();
    chk("ab_rx_valid_count", 32'(rv_cnt - rv0), 32'd1);

    // Reset during MISO bit 3, SS_n held low
    frame(10'h2FF);
    end_frame();
    frame(10'h300);
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h0F;
    rd = 8'h0F;
    for (int k = 7; k >= 3; k--) begin
      @(posedge clk); #1;
      chk($sformatf("rr_miso_bit%0d", k), {31'b0, MISO}, {31'b0, rd[k]});
      tx_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rr_miso", {31'b0, MISO}, 32'd0);
    chk("rr_state", 32'(dut.state_q), 32'(IDLE));
    chk("rr_addr_rcvd", {31'b0, dut.addr_rcvd}, 32'd0);
    chk("rr_rx_data", {22'b0, rx_data}, 32'd0);
    @(negedge clk); rst_n = 1'b1; SS_n = 1'b1;

    // Stray tx_valid across a whole write frame
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
    mh0 = miso_hi_cnt;
    frame(10'h07E);
    repeat (3) @(posedge clk);
    end_frame();
    tx_valid = 1'b0;
    chk("stray_miso", 32'(miso_hi_cnt - mh0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
